// File: rtl/deser_pkg.sv
// Shared types and helpers for the serial deserializer.
package deser_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    localparam logic DIR_LSB_FIRST = 1'b0;
    localparam logic DIR_MSB_FIRST = 1'b1;

    // Bit counter must hold 0..WIDTH.
    function automatic int cnt_w(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/serial_deserializer_if.sv
// Serial bit stream in, parallel word stream out (valid/ready).
interface serial_deserializer_if #(
    parameter int WIDTH = 4
);
    logic             s_din;
    logic             s_valid;
    logic             s_dir;
    logic             s_sync;
    logic [WIDTH-1:0] m_data;
    logic             m_valid;
    logic             m_ready;

    modport master (
        output s_din, s_valid, s_dir, s_sync, m_ready,
        input  m_data, m_valid
    );

    modport slave (
        input  s_din, s_valid, s_dir, s_sync, m_ready,
        output m_data, m_valid
    );
endinterface

// File: rtl/deser_out_buf.sv
// One-entry output holding register: load, drain and drop decision.
module deser_out_buf #(
    parameter int WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             m_ready_i,
    output logic [WIDTH-1:0] m_data_o,
    output logic             m_valid_o,
    output logic             drop_o
);
    logic [WIDTH-1:0] data_q;
    logic             valid_q;

    // A draining buffer accepts a new word on the same edge, so no bubble.
    assign drop_o = load_i && valid_q && !m_ready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else if (load_i && (!valid_q || m_ready_i)) begin
            data_q  <= din_i;
            valid_q <= 1'b1;
        end else if (valid_q && m_ready_i) begin
            valid_q <= 1'b0;
        end
    end

    assign m_data_o  = data_q;
    assign m_valid_o = valid_q;
endmodule

// File: rtl/serial_deserializer.sv
// Serial-in/parallel-out receiver: bit counter, word assembly FSM, sticky flags.
module serial_deserializer
    import deser_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    serial_deserializer_if.slave  bus,
    output logic                  busy_o,
    output logic                  overflow_o,
    output logic                  frame_err_o,
    input  logic                  clr_flags_i
);
    localparam int CW = cnt_w(WIDTH);

    state_e           state_q, state_d;
    logic             dir_q, dir_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CW-1:0]    idx;
    logic             first;
    logic             word_done;
    logic             frame_hit;
    logic             drop;
    logic             overflow_q;
    logic             frame_err_q;
    int               pos;

    // Bits are placed directly at their final position; this yields the same
    // word as a right shift (LSB-first) or left shift (MSB-first).
    always_comb begin
        state_d   = state_q;
        dir_d     = dir_q;
        sh_d      = sh_q;
        cnt_d     = cnt_q;
        word_done = 1'b0;
        frame_hit = 1'b0;
        first     = (cnt_q == '0) || bus.s_sync;
        idx       = first ? '0 : cnt_q;
        pos       = 0;
        if (bus.s_valid) begin
            frame_hit = bus.s_sync && (cnt_q != '0);
            if (first) begin
                dir_d = bus.s_dir;
                sh_d  = '0;
            end
            pos = (dir_d == DIR_MSB_FIRST) ? (WIDTH - 1 - int'(idx)) : int'(idx);
            for (int k = 0; k < WIDTH; k++) begin
                if (k == pos) sh_d[k] = bus.s_din;
            end
            if (int'(idx) == WIDTH - 1) begin
                word_done = 1'b1;
                cnt_d     = '0;
                state_d   = IDLE;
            end else begin
                cnt_d   = idx + CW'(1);
                state_d = SHIFT;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            dir_q       <= DIR_LSB_FIRST;
            sh_q        <= '0;
            cnt_q       <= '0;
            overflow_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            dir_q       <= dir_d;
            sh_q        <= sh_d;
            cnt_q       <= cnt_d;
            // A set event wins over a simultaneous clear.
            overflow_q  <= (overflow_q  & ~clr_flags_i) | drop;
            frame_err_q <= (frame_err_q & ~clr_flags_i) | frame_hit;
        end
    end

    deser_out_buf #(.WIDTH(WIDTH)) u_obuf (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .load_i    (word_done),
        .din_i     (sh_d),
        .m_ready_i (bus.m_ready),
        .m_data_o  (bus.m_data),
        .m_valid_o (bus.m_valid),
        .drop_o    (drop)
    );

    assign busy_o      = (cnt_q != '0);
    assign overflow_o  = overflow_q;
    assign frame_err_o = frame_err_q;
endmodule

// File: tb/tb_serial_deserializer.sv
// Self-checking bench: WIDTH=4 scoreboard plus WIDTH=1 and WIDTH=8 instances.
module tb_serial_deserializer;
    logic clk = 1'b0;
    logic rst;
    logic clr;
    always #5 clk = ~clk;

    serial_deserializer_if #(.WIDTH(4)) b4();
    serial_deserializer_if #(.WIDTH(1)) b1();
    serial_deserializer_if #(.WIDTH(8)) b8();
    logic busy4, ovf4, fe4, busy1, ovf1, fe1, busy8, ovf8, fe8;

    serial_deserializer #(.WIDTH(4)) u4 (.clk_i(clk), .rst_i(rst), .bus(b4.slave),
        .busy_o(busy4), .overflow_o(ovf4), .frame_err_o(fe4), .clr_flags_i(clr));
    serial_deserializer #(.WIDTH(1)) u1 (.clk_i(clk), .rst_i(rst), .bus(b1.slave),
        .busy_o(busy1), .overflow_o(ovf1), .frame_err_o(fe1), .clr_flags_i(clr));
    serial_deserializer #(.WIDTH(8)) u8 (.clk_i(clk), .rst_i(rst), .bus(b8.slave),
        .busy_o(busy8), .overflow_o(ovf8), .frame_err_o(fe8), .clr_flags_i(clr));

    int checks = 0;
    int errors = 0;
    logic [3:0] sb[$];

    // Scoreboard: every handshake on the WIDTH=4 port must match the oldest expected word.
    always @(negedge clk) begin
        if (b4.m_valid && b4.m_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected got=%h (no word expected)", b4.m_data);
            end else begin
                logic [3:0] exp;
                exp = sb.pop_front();
                if (b4.m_data !== exp) begin
                    errors++;
                    $display("FAIL sb_word got=%h exp=%h", b4.m_data, exp);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] model4(input logic [3:0] bits, input logic dir);
        return dir ? {bits[0], bits[1], bits[2], bits[3]} : bits;
    endfunction

    task automatic bit4(input logic din, input logic dir, input logic sync);
        b4.s_din = din; b4.s_dir = dir; b4.s_sync = sync; b4.s_valid = 1'b1;
        tick();
        b4.s_valid = 1'b0; b4.s_sync = 1'b0; b4.s_din = 1'b0;
    endtask

    // bits[k] is the k-th bit sent; dir applies to bit 0, dir_rest to later bits.
    task automatic word4(input logic [3:0] bits, input logic dir, input logic dir_rest,
                         input logic sync0, input int gap, input logic push, input logic chk);
        if (push) sb.push_back(model4(bits, dir));
        for (int k = 0; k < 4; k++) begin
            bit4(bits[k], (k == 0) ? dir : dir_rest, (k == 0) ? sync0 : 1'b0);
            if (k < 3) begin
                for (int g = 0; g <= gap; g++) begin
                    if (chk) begin
                        checks++;
                        if ({busy4, b4.m_valid} !== 2'b10) begin
                            errors++;
                            $display("FAIL mid_word bit=%0d busy/valid got=%b exp=10", k, {busy4, b4.m_valid});
                        end
                    end
                    if (g < gap) tick();
                end
            end
        end
    endtask

    task automatic chk4(input string name, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; tick(); tick(); rst = 1'b0;
        checks++;
        if ({b4.m_valid, b4.m_data, busy4, ovf4, fe4} !== 8'h00) begin
            errors++;
            $display("FAIL reset_state got=%b exp=0", {b4.m_valid, b4.m_data, busy4, ovf4, fe4});
        end
    endtask

    task automatic test_lsb();
        b4.m_ready = 1'b1;
        word4(4'b1101, 1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b1);
        chk4("lsb_valid", {3'b0, b4.m_valid}, 4'h1);
        chk4("lsb_data", b4.m_data, 4'b1101);
        chk4("lsb_busy_done", {3'b0, busy4}, 4'h0);
        tick();
        chk4("lsb_valid_drop", {3'b0, b4.m_valid}, 4'h0);
        chk4("lsb_data_retained", b4.m_data, 4'b1101);
    endtask

    task automatic test_msb();
        word4(4'b1101, 1'b1, 1'b1, 1'b0, 0, 1'b1, 1'b1);
        chk4("msb_data", b4.m_data, 4'b1011);
        tick();
        word4(4'b1101, 1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b1);
        chk4("msb_dir_toggle", b4.m_data, 4'b1011);
        tick();
    endtask

    task automatic test_gaps();
        word4(4'b1101, 1'b0, 1'b0, 1'b0, 2, 1'b1, 1'b1);
        chk4("gap_lsb", b4.m_data, 4'b1101);
        tick();
        word4(4'b1101, 1'b1, 1'b1, 1'b0, 2, 1'b1, 1'b1);
        chk4("gap_msb", b4.m_data, 4'b1011);
        tick();
    endtask

    task automatic test_back_to_back();
        word4(4'h3, 1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0);
        word4(4'hC, 1'b1, 1'b1, 1'b0, 0, 1'b1, 1'b0);
        chk4("b2b_second", b4.m_data, 4'h3);
        tick();
    endtask

    task automatic test_backpressure();
        b4.m_ready = 1'b0;
        word4(4'h5, 1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0);
        word4(4'hA, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        chk4("bp_data_held", b4.m_data, 4'h5);
        chk4("bp_valid_held", {3'b0, b4.m_valid}, 4'h1);
        chk4("bp_overflow", {3'b0, ovf4}, 4'h1);
        b4.m_ready = 1'b1;
        tick();
        chk4("bp_drained", {3'b0, b4.m_valid}, 4'h0);
        chk4("bp_ovf_sticky", {3'b0, ovf4}, 4'h1);
        clr = 1'b1; tick(); clr = 1'b0;
        chk4("bp_ovf_clr", {3'b0, ovf4}, 4'h0);
        // Drop on the same edge as clr_flags: flag must end set.
        b4.m_ready = 1'b0;
        word4(4'h3, 1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0);
        bit4(1'b0, 1'b0, 1'b0); bit4(1'b0, 1'b0, 1'b0); bit4(1'b1, 1'b0, 1'b0);
        clr = 1'b1; bit4(1'b1, 1'b0, 1'b0); clr = 1'b0;
        chk4("bp_set_beats_clr", {3'b0, ovf4}, 4'h1);
        chk4("bp_data_kept", b4.m_data, 4'h3);
        b4.m_ready = 1'b1; tick();
        clr = 1'b1; tick(); clr = 1'b0;
    endtask

    task automatic test_resync();
        b4.m_ready = 1'b1;
        bit4(1'b1, 1'b0, 1'b0); bit4(1'b1, 1'b0, 1'b0);
        chk4("rs_busy", {3'b0, busy4}, 4'h1);
        word4(4'h8, 1'b0, 1'b0, 1'b1, 0, 1'b1, 1'b0);
        chk4("rs_frame_err", {3'b0, fe4}, 4'h1);
        chk4("rs_data", b4.m_data, 4'h8);
        tick();
        clr = 1'b1; tick(); clr = 1'b0;
        chk4("rs_fe_clr", {3'b0, fe4}, 4'h0);
        word4(4'h9, 1'b0, 1'b0, 1'b1, 0, 1'b1, 1'b0);
        chk4("rs_sync_idle_no_err", {3'b0, fe4}, 4'h0);
        chk4("rs_sync_idle_data", b4.m_data, 4'h9);
        tick();
        // Re-sync re-latches direction.
        bit4(1'b1, 1'b0, 1'b0);
        word4(4'b0011, 1'b1, 1'b1, 1'b1, 0, 1'b1, 1'b0);
        chk4("rs_dir_relatch", b4.m_data, 4'b1100);
        chk4("rs_fe_again", {3'b0, fe4}, 4'h1);
        tick();
        clr = 1'b1; tick(); clr = 1'b0;
    endtask

    task automatic test_reset_mid();
        bit4(1'b1, 1'b0, 1'b0); bit4(1'b1, 1'b0, 1'b0);
        rst = 1'b1; tick(); rst = 1'b0;
        checks++;
        if ({b4.m_valid, b4.m_data, busy4} !== 6'h00) begin
            errors++;
            $display("FAIL rst_mid_word got=%b exp=0", {b4.m_valid, b4.m_data, busy4});
        end
        b4.m_ready = 1'b0;
        word4(4'h7, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        chk4("rst_pre_valid", {3'b0, b4.m_valid}, 4'h1);
        rst = 1'b1; tick(); rst = 1'b0;
        checks++;
        if ({b4.m_valid, b4.m_data, busy4, ovf4, fe4} !== 8'h00) begin
            errors++;
            $display("FAIL rst_with_valid got=%b exp=0", {b4.m_valid, b4.m_data, busy4, ovf4, fe4});
        end
        b4.m_ready = 1'b1;
        word4(4'hE, 1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b1);
        chk4("rst_clean_word", b4.m_data, 4'hE);
        tick();
    endtask

    task automatic bit1(input logic din);
        b1.s_din = din; b1.s_dir = 1'b0; b1.s_valid = 1'b1;
        tick();
        b1.s_valid = 1'b0;
    endtask

    task automatic test_w1();
        logic [2:0] pat;
        pat = 3'b101;
        b1.m_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            bit1(pat[k]);
            checks++;
            if ({b1.m_valid, b1.m_data, busy1} !== {1'b1, pat[k], 1'b0}) begin
                errors++;
                $display("FAIL w1_word k=%0d got=%b exp=%b", k, {b1.m_valid, b1.m_data, busy1}, {1'b1, pat[k], 1'b0});
            end
        end
        tick();
        chk4("w1_drained", {3'b0, b1.m_valid}, 4'h0);
        b1.m_ready = 1'b0;
        bit1(1'b1); bit1(1'b0);
        chk4("w1_overflow", {2'b0, b1.m_data, ovf1}, 4'h3);
        b1.m_ready = 1'b1; tick();
    endtask

    task automatic word8(input logic [7:0] bits, input logic dir);
        for (int k = 0; k < 8; k++) begin
            b8.s_din = bits[k]; b8.s_dir = dir; b8.s_valid = 1'b1;
            tick();
            b8.s_valid = 1'b0;
            if (k == 3) chk4("w8_busy", {3'b0, busy8}, 4'h1);
        end
    endtask

    task automatic test_w8();
        b8.m_ready = 1'b1;
        word8(8'hA5, 1'b0);
        checks++;
        if ({b8.m_valid, b8.m_data} !== 9'h1A5) begin
            errors++;
            $display("FAIL w8_lsb got=%h exp=1a5", {b8.m_valid, b8.m_data});
        end
        tick();
        word8(8'h01, 1'b1);
        checks++;
        if ({b8.m_valid, b8.m_data} !== 9'h180) begin
            errors++;
            $display("FAIL w8_msb got=%h exp=180", {b8.m_valid, b8.m_data});
        end
        tick();
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0;
        b4.s_din = 0; b4.s_valid = 0; b4.s_dir = 0; b4.s_sync = 0; b4.m_ready = 0;
        b1.s_din = 0; b1.s_valid = 0; b1.s_dir = 0; b1.s_sync = 0; b1.m_ready = 0;
        b8.s_din = 0; b8.s_valid = 0; b8.s_dir = 0; b8.s_sync = 0; b8.m_ready = 0;
        test_reset();
        test_lsb();
        test_msb();
        test_gaps();
        test_back_to_back();
        test_backpressure();
        test_resync();
        test_reset_mid();
        test_w1();
        test_w8();
        tick();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover got=%0d exp=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
